// File: rtl/dmem_arbiter_if.sv
// Bus bundle for the data-memory arbiter: CPU requester port, loader
// requester port, data-memory port and status outputs. The slave modport is
// the arbiter's view; the master modport is the view of the surrounding system.
interface dmem_arbiter_if #(
    parameter int ADDR_WIDTH = 14,
    parameter int DATA_WIDTH = 32
);
    // CPU load/store side
    logic                  cpu_req;
    logic                  cpu_we;
    logic [ADDR_WIDTH-1:0] cpu_addr;
    logic [DATA_WIDTH-1:0] cpu_wdata;
    logic [DATA_WIDTH-1:0] cpu_rdata;
    logic                  cpu_ack;
    logic                  cpu_stall;

    // UART loader side
    logic                  ldr_req;
    logic                  ldr_we;
    logic [ADDR_WIDTH-1:0] ldr_addr;
    logic [DATA_WIDTH-1:0] ldr_wdata;
    logic [DATA_WIDTH-1:0] ldr_rdata;
    logic                  ldr_ack;

    // Data memory (block RAM, one-cycle read latency)
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;

    // Current bus owner: 00 none, 01 CPU, 10 loader
    logic [1:0]            owner;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_ack, cpu_stall,
        input  ldr_req, ldr_we, ldr_addr, ldr_wdata,
        output ldr_rdata, ldr_ack,
        output mem_we, mem_addr, mem_wdata,
        input  mem_rdata,
        output owner
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_ack, cpu_stall,
        output ldr_req, ldr_we, ldr_addr, ldr_wdata,
        input  ldr_rdata, ldr_ack,
        input  mem_we, mem_addr, mem_wdata,
        output mem_rdata,
        input  owner
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: shares one synchronous-read block-RAM port between the
// CPU load/store path and the UART loader. Every access runs IDLE -> ISSUE ->
// RESP, the CPU is stalled until its access completes, and a bounded-priority
// counter forces the loader in after STARVE_LIMIT consecutive CPU wins.
module dmem_arbiter #(
    parameter int ADDR_WIDTH   = 14,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 8
) (
    input  logic             clock,
    input  logic             reset,
    dmem_arbiter_if.slave    bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_CPU  = 2'b01;
    localparam logic [1:0] OWN_LDR  = 2'b10;
    localparam logic [7:0] LIMIT    = 8'(STARVE_LIMIT);

    state_t                r_state;
    state_t                w_state_nxt;

    logic [7:0]            r_starve_cnt;
    logic [7:0]            w_starve_cnt_nxt;
    logic                  r_win_ldr;
    logic                  w_win_ldr_nxt;
    logic                  r_win_we;
    logic                  w_win_we_nxt;

    logic                  r_mem_we;
    logic                  w_mem_we_nxt;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [ADDR_WIDTH-1:0] w_mem_addr_nxt;
    logic [DATA_WIDTH-1:0] r_mem_wdata;
    logic [DATA_WIDTH-1:0] w_mem_wdata_nxt;

    logic [DATA_WIDTH-1:0] r_cpu_rdata;
    logic [DATA_WIDTH-1:0] w_cpu_rdata_nxt;
    logic                  r_cpu_ack;
    logic                  w_cpu_ack_nxt;
    logic [DATA_WIDTH-1:0] r_ldr_rdata;
    logic [DATA_WIDTH-1:0] w_ldr_rdata_nxt;
    logic                  r_ldr_ack;
    logic                  w_ldr_ack_nxt;
    logic [1:0]            r_owner;
    logic [1:0]            w_owner_nxt;

    logic                  w_cpu_eff;
    logic                  w_ldr_eff;
    logic                  w_any_req;
    logic                  w_pick_ldr;

    // A port whose ack is showing this cycle is finished; masking it stops a
    // second access being granted while the requester is still dropping req.
    assign w_cpu_eff  = bus.cpu_req & ~r_cpu_ack;
    assign w_ldr_eff  = bus.ldr_req & ~r_ldr_ack;
    assign w_any_req  = w_cpu_eff | w_ldr_eff;
    // CPU has priority unless the loader has waited through LIMIT CPU grants.
    assign w_pick_ldr = w_ldr_eff & (~w_cpu_eff | (r_starve_cnt == LIMIT));

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode: one grant walks ISSUE then RESP before returning
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_any_req) w_state_nxt = S_ISSUE;
            S_ISSUE: w_state_nxt = S_RESP;
            S_RESP:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output decode: next values of the registered outputs and latched winner
    always_comb begin
        w_win_ldr_nxt    = r_win_ldr;
        w_win_we_nxt     = r_win_we;
        w_mem_we_nxt     = r_mem_we;
        w_mem_addr_nxt   = r_mem_addr;
        w_mem_wdata_nxt  = r_mem_wdata;
        w_cpu_rdata_nxt  = r_cpu_rdata;
        w_ldr_rdata_nxt  = r_ldr_rdata;
        w_cpu_ack_nxt    = 1'b0;
        w_ldr_ack_nxt    = 1'b0;
        w_owner_nxt      = r_owner;
        w_starve_cnt_nxt = r_starve_cnt;

        case (r_state)
            S_IDLE: begin
                w_owner_nxt  = OWN_NONE;
                w_mem_we_nxt = 1'b0;
                if (w_any_req) begin
                    // Requester inputs are captured only here; later changes are ignored
                    w_win_ldr_nxt = w_pick_ldr;
                    if (w_pick_ldr) begin
                        w_win_we_nxt    = bus.ldr_we;
                        w_mem_we_nxt    = bus.ldr_we;
                        w_mem_addr_nxt  = bus.ldr_addr;
                        w_mem_wdata_nxt = bus.ldr_wdata;
                        w_owner_nxt     = OWN_LDR;
                    end else begin
                        w_win_we_nxt    = bus.cpu_we;
                        w_mem_we_nxt    = bus.cpu_we;
                        w_mem_addr_nxt  = bus.cpu_addr;
                        w_mem_wdata_nxt = bus.cpu_wdata;
                        w_owner_nxt     = OWN_CPU;
                    end
                end
            end
            S_ISSUE: begin
                // Memory samples the access at the end of this cycle; a write
                // must not repeat, address and data simply hold.
                w_mem_we_nxt = 1'b0;
            end
            S_RESP: begin
                if (!r_win_we) begin
                    if (r_win_ldr) begin
                        w_ldr_rdata_nxt = bus.mem_rdata;
                    end else begin
                        w_cpu_rdata_nxt = bus.mem_rdata;
                    end
                end
                if (r_win_ldr) begin
                    w_ldr_ack_nxt = 1'b1;
                end else begin
                    w_cpu_ack_nxt = 1'b1;
                end
                w_owner_nxt = OWN_NONE;
            end
            default: begin
                w_owner_nxt  = OWN_NONE;
                w_mem_we_nxt = 1'b0;
            end
        endcase

        // Starvation counter follows raw ldr_req: any cycle without a loader
        // request, or a loader grant, clears it; CPU grants while the loader
        // is requesting count up to LIMIT.
        if (!bus.ldr_req) begin
            w_starve_cnt_nxt = 8'd0;
        end else if ((r_state == S_IDLE) && w_any_req) begin
            if (w_pick_ldr) begin
                w_starve_cnt_nxt = 8'd0;
            end else if (r_starve_cnt != LIMIT) begin
                w_starve_cnt_nxt = r_starve_cnt + 8'd1;
            end
        end
    end

    // Output and arbitration registers; reset drops any access in flight
    always_ff @(posedge clock) begin
        if (reset) begin
            r_starve_cnt <= 8'd0;
            r_win_ldr    <= 1'b0;
            r_win_we     <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_cpu_rdata  <= '0;
            r_cpu_ack    <= 1'b0;
            r_ldr_rdata  <= '0;
            r_ldr_ack    <= 1'b0;
            r_owner      <= OWN_NONE;
        end else begin
            r_starve_cnt <= w_starve_cnt_nxt;
            r_win_ldr    <= w_win_ldr_nxt;
            r_win_we     <= w_win_we_nxt;
            r_mem_we     <= w_mem_we_nxt;
            r_mem_addr   <= w_mem_addr_nxt;
            r_mem_wdata  <= w_mem_wdata_nxt;
            r_cpu_rdata  <= w_cpu_rdata_nxt;
            r_cpu_ack    <= w_cpu_ack_nxt;
            r_ldr_rdata  <= w_ldr_rdata_nxt;
            r_ldr_ack    <= w_ldr_ack_nxt;
            r_owner      <= w_owner_nxt;
        end
    end

    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.cpu_rdata = r_cpu_rdata;
    assign bus.cpu_ack   = r_cpu_ack;
    assign bus.ldr_rdata = r_ldr_rdata;
    assign bus.ldr_ack   = r_ldr_ack;
    assign bus.owner     = r_owner;
    // Stall is combinational so the CPU freezes in the very cycle it requests
    assign bus.cpu_stall = bus.cpu_req & ~r_cpu_ack & ~reset;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized scoreboard bench for dmem_arbiter with a block-RAM model and a
// transaction-level reference of the arbitration rules.
module tb_dmem_arbiter;

    localparam int AW   = 14;
    localparam int DW   = 32;
    localparam int LIM  = 2;
    localparam int NCYC = 4000;
    localparam int MAXC = NCYC + 128;

    typedef struct {
        int            cyc;
        logic [DW-1:0] rdata;
    } ack_t;

    typedef struct {
        int            cyc;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } acc_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    dmem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus();

    dmem_arbiter #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .STARVE_LIMIT(LIM)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    // Block RAM with synchronous read
    logic [DW-1:0] mem [0:(1<<AW)-1];
    always @(posedge clock) begin
        if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
        bus.mem_rdata <= mem[bus.mem_addr];
    end

    // Reference state
    logic [DW-1:0] shadow [0:(1<<AW)-1];
    logic          exp_stall [0:MAXC];
    logic [1:0]    exp_owner [0:MAXC];
    bit            rst_chk   [0:MAXC];
    ack_t          cpu_q[$];
    ack_t          ldr_q[$];
    acc_t          mem_q[$];
    int            m_free = 0;
    int            m_cpu_ack = -1;
    int            m_ldr_ack = -1;
    int            m_cnt = 0;
    logic [DW-1:0] held_cpu = '0;
    logic [DW-1:0] held_ldr = '0;

    // Requester state
    bit p_cpu_pend = 0, p_cpu_gr = 0, p_ldr_pend = 0, p_ldr_gr = 0;

    int cyc = 0;
    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [AW-1:0] rand_addr();
        logic [AW-1:0] a;
        if ($urandom_range(0, 3) == 0) a = AW'($urandom);
        else                           a = AW'($urandom_range(0, 63));
        if (a == AW'(12'h030)) a = AW'(12'h031);
        return a;
    endfunction

    task automatic next_cycle();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    // Reference model: a request seen while the port is free is served three
    // cycles later; reset abandons whatever has not yet been acknowledged.
    task automatic model_cycle();
        logic ca, la, ce, le, tl, g, we;
        logic [AW-1:0] a;
        logic [DW-1:0] wd;
        ca = (m_cpu_ack == cyc);
        la = (m_ldr_ack == cyc);
        exp_stall[cyc] = bus.cpu_req & ~ca & ~reset;
        if (reset) begin
            for (int i = cpu_q.size() - 1; i >= 0; i--) if (cpu_q[i].cyc > cyc) cpu_q.delete(i);
            for (int i = ldr_q.size() - 1; i >= 0; i--) if (ldr_q[i].cyc > cyc) ldr_q.delete(i);
            for (int i = mem_q.size() - 1; i >= 0; i--) if (mem_q[i].cyc > cyc) mem_q.delete(i);
            exp_owner[cyc+1] = 2'b00;
            exp_owner[cyc+2] = 2'b00;
            if (m_cpu_ack > cyc) begin m_cpu_ack = -1; p_cpu_gr = 0; end
            if (m_ldr_ack > cyc) begin m_ldr_ack = -1; p_ldr_gr = 0; end
            m_free = cyc + 1;
            m_cnt = 0;
            held_cpu = '0;
            held_ldr = '0;
            rst_chk[cyc+1] = 1;
        end else begin
            g = 0;
            tl = 0;
            if (cyc >= m_free) begin
                ce = bus.cpu_req & ~ca;
                le = bus.ldr_req & ~la;
                if (ce | le) begin
                    g = 1;
                    tl = le && (!ce || m_cnt == LIM);
                    we = tl ? bus.ldr_we    : bus.cpu_we;
                    a  = tl ? bus.ldr_addr  : bus.cpu_addr;
                    wd = tl ? bus.ldr_wdata : bus.cpu_wdata;
                    if (we) shadow[a] = wd;
                    else if (tl) held_ldr = shadow[a];
                    else held_cpu = shadow[a];
                    if (tl) begin
                        ldr_q.push_back('{cyc + 3, held_ldr});
                        m_ldr_ack = cyc + 3;
                        p_ldr_gr = 1;
                    end else begin
                        cpu_q.push_back('{cyc + 3, held_cpu});
                        m_cpu_ack = cyc + 3;
                        p_cpu_gr = 1;
                    end
                    mem_q.push_back('{cyc + 1, we, a, wd});
                    exp_owner[cyc+1] = tl ? 2'b10 : 2'b01;
                    exp_owner[cyc+2] = tl ? 2'b10 : 2'b01;
                    m_free = cyc + 3;
                end
            end
            if (!bus.ldr_req)      m_cnt = 0;
            else if (g && tl)      m_cnt = 0;
            else if (g && m_cnt < LIM) m_cnt++;
        end
    endtask

    task automatic random_drive(input int rate, input bit allow_rst);
        reset = (cyc < 3) || (allow_rst && cyc > 40 && $urandom_range(0, 249) == 0);
        if (m_cpu_ack == cyc) begin p_cpu_pend = 0; p_cpu_gr = 0; end
        if (m_ldr_ack == cyc) begin p_ldr_pend = 0; p_ldr_gr = 0; end
        if (cyc == 3) begin
            p_cpu_pend = 1; bus.cpu_we = 1'b0; bus.cpu_addr = AW'(12'h010); bus.cpu_wdata = '0;
            p_ldr_pend = 1; bus.ldr_we = 1'b1; bus.ldr_addr = AW'(12'h020); bus.ldr_wdata = 32'h12345678;
        end else begin
            if (!p_cpu_pend) begin
                if ($urandom_range(0, 99) < rate) begin
                    p_cpu_pend = 1;
                    bus.cpu_we = 1'($urandom_range(0, 1));
                    bus.cpu_addr = rand_addr();
                    bus.cpu_wdata = $urandom;
                end
            end else if (p_cpu_gr) begin
                bus.cpu_we = 1'($urandom_range(0, 1));
                bus.cpu_addr = rand_addr();
                bus.cpu_wdata = $urandom;
            end
            if (!p_ldr_pend) begin
                if ($urandom_range(0, 99) < rate) begin
                    p_ldr_pend = 1;
                    bus.ldr_we = 1'($urandom_range(0, 1));
                    bus.ldr_addr = rand_addr();
                    bus.ldr_wdata = $urandom;
                end
            end else if (p_ldr_gr) begin
                bus.ldr_we = 1'($urandom_range(0, 1));
                bus.ldr_addr = rand_addr();
                bus.ldr_wdata = $urandom;
            end
        end
        bus.cpu_req = p_cpu_pend;
        bus.ldr_req = p_ldr_pend;
    endtask

    // Monitor: compares DUT outputs against the scoreboard mid-cycle
    initial begin
        forever begin
            @(negedge clock);
            if (cyc >= 1) begin
                chk("cpu_stall", 32'(bus.cpu_stall), 32'(exp_stall[cyc]));
                chk("owner", 32'(bus.owner), 32'(exp_owner[cyc]));
                if (cpu_q.size() > 0 && cpu_q[0].cyc == cyc) begin
                    chk("cpu_ack", 32'(bus.cpu_ack), 32'd1);
                    chk("cpu_rdata", bus.cpu_rdata, cpu_q[0].rdata);
                    void'(cpu_q.pop_front());
                end else begin
                    chk("cpu_ack", 32'(bus.cpu_ack), 32'd0);
                end
                if (ldr_q.size() > 0 && ldr_q[0].cyc == cyc) begin
                    chk("ldr_ack", 32'(bus.ldr_ack), 32'd1);
                    chk("ldr_rdata", bus.ldr_rdata, ldr_q[0].rdata);
                    void'(ldr_q.pop_front());
                end else begin
                    chk("ldr_ack", 32'(bus.ldr_ack), 32'd0);
                end
                if (mem_q.size() > 0 && mem_q[0].cyc == cyc) begin
                    chk("mem_we", 32'(bus.mem_we), 32'(mem_q[0].we));
                    chk("mem_addr", 32'(bus.mem_addr), 32'(mem_q[0].addr));
                    if (mem_q[0].we) chk("mem_wdata", bus.mem_wdata, mem_q[0].wdata);
                    void'(mem_q.pop_front());
                end else begin
                    chk("mem_we", 32'(bus.mem_we), 32'd0);
                end
                if (rst_chk[cyc]) begin
                    chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
                    chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
                    chk("rst_cpu_rdata", bus.cpu_rdata, 32'd0);
                    chk("rst_ldr_rdata", bus.ldr_rdata, 32'd0);
                end
            end
        end
    end

    // Stimulus and reference model
    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            mem[i]    = 32'(i) * 32'h9E3779B1;
            shadow[i] = 32'(i) * 32'h9E3779B1;
        end
        mem[12'h010] = 32'hDEADBEEF; shadow[12'h010] = 32'hDEADBEEF;
        mem[12'h030] = 32'hAAAA5555; shadow[12'h030] = 32'hAAAA5555;
        for (int i = 0; i <= MAXC; i++) begin
            exp_stall[i] = 1'b0;
            exp_owner[i] = 2'b00;
        end
        bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        bus.ldr_req = 0; bus.ldr_we = 0; bus.ldr_addr = '0; bus.ldr_wdata = '0;
        reset = 1'b1;
        model_cycle();

        for (int k = 1; k < NCYC; k++) begin
            int rate;
            next_cycle();
            case ((cyc / 500) % 4)
                0: rate = 100;
                1: rate = 50;
                2: rate = 15;
                default: rate = 80;
            endcase
            random_drive(rate, 1'b1);
            model_cycle();
        end

        // Let outstanding requests drain
        for (int k = 0; k < 12; k++) begin
            next_cycle();
            random_drive(0, 1'b0);
            model_cycle();
        end

        // Reset lands in the grant cycle of a loader write: nothing may happen
        next_cycle();
        reset = 1'b1;
        bus.cpu_req = 1'b0;
        bus.ldr_req = 1'b1; bus.ldr_we = 1'b1;
        bus.ldr_addr = AW'(12'h030); bus.ldr_wdata = 32'h55AA55AA;
        model_cycle();
        next_cycle();
        reset = 1'b0;
        bus.ldr_req = 1'b0;
        model_cycle();
        for (int k = 0; k < 10; k++) begin
            next_cycle();
            random_drive(0, 1'b0);
            model_cycle();
        end

        chk("mem_0x030_kept", mem[12'h030], 32'hAAAA5555);
        chk("cpu_q_drained", 32'(cpu_q.size()), 32'd0);
        chk("ldr_q_drained", 32'(ldr_q.size()), 32'd0);
        chk("mem_q_drained", 32'(mem_q.size()), 32'd0);
        for (int i = 0; i < 64; i++) chk("mem_contents", mem[i], shadow[i]);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
